// File: rtl/cache_sram_assoc.sv
// N-way set-associative tag/data store with registered 1-cycle read.
// Lookup compares tags in all ways; misses report the LRU/invalid victim.
module cache_sram_assoc #(
    parameter  int SETS   = 16,
    parameter  int WAYS   = 2,
    parameter  int TAG_W  = 22,
    parameter  int DATA_W = 256,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clock_i,
    input  logic              rst_i,
    output logic              ready_o,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [WAY_W-1:0]  way_i,
    input  logic              valid_i,
    input  logic              dirty_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              resp_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] sweep_q;

    logic [WAYS-1:0]   val_q  [SETS];
    logic [WAYS-1:0]   dty_q  [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [DATA_W-1:0] data_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q  [SETS][WAYS];

    logic             accept;
    logic             any_hit;
    logic             touch;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] max_age;
    logic [WAY_W-1:0] sel_way;

    assign accept = enable_i & ready_o;

    always_comb begin
        any_hit = 1'b0;
        hit_way = '0;
        vic_way = '0;
        max_age = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (val_q[index_i][w] && (tag_q[index_i][w] == tag_i)) begin
                any_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[index_i][w] > max_age) begin
                max_age = age_q[index_i][w];
                vic_way = WAY_W'(w);
            end
        end
        // an empty way always beats the oldest one
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!val_q[index_i][w]) begin
                vic_way = WAY_W'(w);
            end
        end
    end

    assign sel_way = write_i ? way_i : (any_hit ? hit_way : vic_way);
    assign touch   = accept & (write_i | any_hit);

    always_ff @(posedge clock_i) begin
        if (state_q == S_INIT) begin
            val_q[sweep_q] <= '0;
            dty_q[sweep_q] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                age_q[sweep_q][w] <= WAY_W'(w);
            end
        end else if (accept) begin
            if (write_i) begin
                val_q[index_i][way_i]  <= valid_i;
                dty_q[index_i][way_i]  <= dirty_i;
                tag_q[index_i][way_i]  <= tag_i;
                data_q[index_i][way_i] <= data_i;
            end
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == sel_way) begin
                        age_q[index_i][w] <= '0;
                    end else if (age_q[index_i][w] < age_q[index_i][sel_way]) begin
                        age_q[index_i][w] <= age_q[index_i][w] + WAY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ready_o <= 1'b0;
            resp_o  <= 1'b0;
            hit_o   <= 1'b0;
            way_o   <= '0;
            valid_o <= 1'b0;
            dirty_o <= 1'b0;
            tag_o   <= '0;
            data_o  <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    resp_o  <= 1'b0;
                    sweep_q <= sweep_q + IDX_W'(1);
                    if (sweep_q == IDX_W'(SETS - 1)) begin
                        state_q <= S_RUN;
                        ready_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    resp_o <= accept;
                    if (accept) begin
                        hit_o   <= ~write_i & any_hit;
                        way_o   <= sel_way;
                        valid_o <= val_q[index_i][sel_way];
                        dirty_o <= dty_q[index_i][sel_way];
                        tag_o   <= tag_q[index_i][sel_way];
                        data_o  <= data_q[index_i][sel_way];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sram_assoc.sv
// Bench for cache_sram_assoc: a 2-way and a 4-way instance checked
// every cycle against a recency-list model plus literal expectations.
module tb_cache_sram_assoc;

    localparam int SETS = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         en  [2];
    logic         wr  [2];
    logic         vi  [2];
    logic         di  [2];
    logic [3:0]   idx [2];
    logic [21:0]  tg  [2];
    logic [1:0]   wy  [2];
    logic [255:0] dat [2];

    logic         rdy  [2];
    logic         resp [2];
    logic         hit  [2];
    logic         vo   [2];
    logic         dout [2];
    logic [21:0]  to   [2];
    logic [255:0] dato [2];
    logic [0:0]   way_a;
    logic [1:0]   way_b;
    logic [1:0]   rway [2];

    assign rway[0] = {1'b0, way_a};
    assign rway[1] = way_b;

    cache_sram_assoc #(.SETS(SETS), .WAYS(2), .TAG_W(22), .DATA_W(256)) u_dut2 (
        .clock_i(clk), .rst_i(rst_n), .ready_o(rdy[0]),
        .enable_i(en[0]), .write_i(wr[0]), .index_i(idx[0]),
        .tag_i(tg[0]), .way_i(wy[0][0:0]), .valid_i(vi[0]),
        .dirty_i(di[0]), .data_i(dat[0]), .resp_o(resp[0]),
        .hit_o(hit[0]), .way_o(way_a), .valid_o(vo[0]),
        .dirty_o(dout[0]), .tag_o(to[0]), .data_o(dato[0])
    );

    cache_sram_assoc #(.SETS(SETS), .WAYS(4), .TAG_W(22), .DATA_W(256)) u_dut4 (
        .clock_i(clk), .rst_i(rst_n), .ready_o(rdy[1]),
        .enable_i(en[1]), .write_i(wr[1]), .index_i(idx[1]),
        .tag_i(tg[1]), .way_i(wy[1]), .valid_i(vi[1]),
        .dirty_i(di[1]), .data_i(dat[1]), .resp_o(resp[1]),
        .hit_o(hit[1]), .way_o(way_b), .valid_o(vo[1]),
        .dirty_o(dout[1]), .tag_o(to[1]), .data_o(dato[1])
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(string nm, int d, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d got %h want %h", nm, d, act, exp);
        end
    endtask

    // Model: contents per way plus a recency list (front = most recent).
    bit           m_val   [2][16][4];
    bit           m_dty   [2][16][4];
    bit           m_known [2][16][4];
    logic [21:0]  m_tag   [2][16][4];
    logic [255:0] m_dat   [2][16][4];
    int           m_order [2][16][4];
    int           m_cnt;
    bit           m_rdy;

    bit           e_resp  [2];
    bit           e_hit   [2];
    bit           e_val   [2];
    bit           e_dty   [2];
    bit           e_known [2];
    int           e_way   [2];
    logic [21:0]  e_tag   [2];
    logic [255:0] e_dat   [2];

    function automatic int nways(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic touch(int d, int s, int w);
        int p = 0;
        for (int i = 0; i < nways(d); i++)
            if (m_order[d][s][i] == w) p = i;
        for (int i = p; i > 0; i--)
            m_order[d][s][i] = m_order[d][s][i-1];
        m_order[d][s][0] = w;
    endtask

    task automatic model_op(int d);
        int s = int'(idx[d]);
        int n = nways(d);
        int w = -1;
        bit h;
        if (!wr[d])
            for (int i = 0; i < n; i++)
                if (w < 0 && m_val[d][s][i] && m_tag[d][s][i] == tg[d]) w = i;
        h = (w >= 0);
        if (wr[d]) begin
            w = int'(wy[d]);
        end else if (!h) begin
            for (int i = 0; i < n; i++)
                if (w < 0 && !m_val[d][s][i]) w = i;
            if (w < 0) w = m_order[d][s][n-1];
        end
        e_resp[d]  = 1'b1;
        e_hit[d]   = h;
        e_way[d]   = w;
        e_val[d]   = m_val[d][s][w];
        e_dty[d]   = m_dty[d][s][w];
        e_known[d] = m_known[d][s][w];
        e_tag[d]   = m_tag[d][s][w];
        e_dat[d]   = m_dat[d][s][w];
        if (wr[d]) begin
            m_val[d][s][w]   = vi[d];
            m_dty[d][s][w]   = di[d];
            m_tag[d][s][w]   = tg[d];
            m_dat[d][s][w]   = dat[d];
            m_known[d][s][w] = 1'b1;
        end
        if (wr[d] || h) touch(d, s, w);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_rdy = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e_resp[d] = 1'b0;
                for (int s = 0; s < 16; s++)
                    for (int w = 0; w < 4; w++) begin
                        m_val[d][s][w]   = 1'b0;
                        m_dty[d][s][w]   = 1'b0;
                        m_order[d][s][w] = w;
                    end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_resp[d] = 1'b0;
                if (m_rdy && en[d]) model_op(d);
            end
            if (!m_rdy) begin
                m_cnt++;
                if (m_cnt == SETS) m_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("ready", d, 256'(rdy[d]), 256'(m_rdy));
                chk("resp", d, 256'(resp[d]), 256'(e_resp[d]));
                if (e_resp[d]) begin
                    chk("hit", d, 256'(hit[d]), 256'(e_hit[d]));
                    chk("way", d, 256'(rway[d]), 256'(e_way[d]));
                    chk("valid", d, 256'(vo[d]), 256'(e_val[d]));
                    chk("dirty", d, 256'(dout[d]), 256'(e_dty[d]));
                    if (e_known[d]) begin
                        chk("tag", d, 256'(to[d]), 256'(e_tag[d]));
                        chk("data", d, dato[d], e_dat[d]);
                    end
                end
            end
        end
    end

    task automatic op(int d, bit w, int s, logic [21:0] t, int way,
                      bit v, bit dt, logic [255:0] data);
        en[d]  = 1'b1;
        wr[d]  = w;
        idx[d] = 4'(s);
        tg[d]  = t;
        wy[d]  = 2'(way);
        vi[d]  = v;
        di[d]  = dt;
        dat[d] = data;
        @(negedge clk);
    endtask

    task automatic idle();
        en[0] = 1'b0;
        en[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int cnt = 0;
        while (rdy[0] !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("init_cycles", 0, 256'(cnt), 256'(16));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [255:0] pat_a5;
    logic [255:0] pat_3c;

    initial begin
        pat_a5 = {8{32'hA5A5A5A5}};
        pat_3c = {8{32'h3C3C0F0F}};
        for (int d = 0; d < 2; d++) begin
            en[d] = 0; wr[d] = 0; vi[d] = 0; di[d] = 0;
            idx[d] = '0; tg[d] = '0; wy[d] = '0; dat[d] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, 256'(rdy[0]), 256'(0));
        chk("rst_resp", 0, 256'(resp[0]), 256'(0));
        chk("rst_way", 1, 256'(way_b), 256'(0));
        chk("rst_data", 0, dato[0], 256'(0));

        // enable held high through the init sweep
        en[0] = 1'b1; wr[0] = 1'b0; idx[0] = 4'd7; tg[0] = 22'h1;
        rst_n = 1'b1;
        wait_ready();
        @(negedge clk);
        chk("t1_resp", 0, 256'(resp[0]), 256'(1));
        chk("t1_hit", 0, 256'(hit[0]), 256'(0));
        chk("t1_valid", 0, 256'(vo[0]), 256'(0));
        idle();

        op(0, 1, 3, 22'h12345, 1, 1, 0, pat_a5);
        chk("t2_wr_valid", 0, 256'(vo[0]), 256'(0));
        op(0, 0, 3, 22'h12345, 0, 0, 0, '0);
        chk("t2_hit", 0, 256'(hit[0]), 256'(1));
        chk("t2_way", 0, 256'(way_a), 256'(1));
        chk("t2_data", 0, dato[0], pat_a5);

        op(0, 1, 5, 22'hA, 0, 1, 0, pat_3c);
        op(0, 1, 5, 22'hB, 1, 1, 0, ~pat_3c);
        op(0, 0, 5, 22'hA, 0, 0, 0, '0);
        chk("t3_hitA", 0, 256'(hit[0]), 256'(1));
        op(0, 0, 5, 22'hC, 0, 0, 0, '0);
        chk("t3_miss_way", 0, 256'(way_a), 256'(1));
        chk("t3_miss_tag", 0, 256'(to[0]), 256'(22'hB));
        op(0, 0, 4, 22'h7, 0, 0, 0, '0);
        chk("empty_victim", 0, 256'(way_a), 256'(0));

        op(0, 1, 5, 22'hC, 1, 1, 1, pat_a5);
        chk("t4_old_valid", 0, 256'(vo[0]), 256'(1));
        chk("t4_old_tag", 0, 256'(to[0]), 256'(22'hB));
        op(0, 0, 5, 22'hC, 0, 0, 0, '0);
        chk("t4_hit", 0, 256'(hit[0]), 256'(1));
        chk("t4_dirty", 0, 256'(dout[0]), 256'(1));

        op(0, 0, 3, 22'h12345, 0, 0, 0, '0);
        op(0, 0, 5, 22'hA, 0, 0, 0, '0);
        #2 rst_n = 1'b0;
        #1 chk("t5_resp_drop", 0, 256'(resp[0]), 256'(0));
        en[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        op(0, 0, 3, 22'h12345, 0, 0, 0, '0);
        chk("t5_miss3", 0, 256'(hit[0]), 256'(0));
        op(0, 0, 5, 22'hC, 0, 0, 0, '0);
        chk("t5_miss5", 0, 256'(hit[0]), 256'(0));
        op(0, 0, 5, 22'hA, 0, 0, 0, '0);
        idle();

        for (int w = 0; w < 4; w++)
            op(1, 1, 2, 22'h100 + 22'(w), w, 1, w[0], {8{32'(w) * 32'h01010101}});
        for (int w = 0; w < 4; w++)
            op(1, 0, 2, 22'h100 + 22'(w), 0, 0, 0, '0);
        op(1, 0, 2, 22'h1FF, 0, 0, 0, '0);
        chk("t6_lru0", 1, 256'(way_b), 256'(0));
        op(1, 0, 2, 22'h100, 0, 0, 0, '0);
        op(1, 0, 2, 22'h1FF, 0, 0, 0, '0);
        chk("t6_lru1", 1, 256'(way_b), 256'(1));

        op(1, 1, 9, 22'h55, 2, 1, 0, pat_a5);
        op(1, 0, 9, 22'h66, 0, 0, 0, '0);
        chk("t6_inv0", 1, 256'(way_b), 256'(0));
        op(1, 1, 9, 22'h66, 0, 1, 1, pat_3c);
        op(1, 0, 9, 22'h77, 0, 0, 0, '0);
        chk("t6_inv1", 1, 256'(way_b), 256'(1));
        op(1, 0, 9, 22'h55, 0, 0, 0, '0);
        chk("t6_hit2", 1, 256'(way_b), 256'(2));
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
